// File: rtl/spn_stream.sv
// Streaming block permuter: double-buffered banks of BLOCK words, written LANES per beat and read
// out in a mode-selected order. Define SPN_BITREV_EN to enable the bit-reversal mode (mode 2).

module spn_stream #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned LANES      = 4,
   parameter int unsigned BLOCK      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] input_stream  [LANES-1:0],
   input  logic                  valid_in,
   input  logic [1:0]            mode,
   output logic [DATA_WIDTH-1:0] output_stream [LANES-1:0],
   output logic                  valid_out,
   output logic                  sob_out
);

   localparam int unsigned R     = BLOCK / LANES;
   localparam int unsigned IDX_W = (BLOCK > 1) ? $clog2(BLOCK) : 1;
   localparam int unsigned CNT_W = (R > 1) ? $clog2(R) : 1;

   typedef enum logic [0:0] {StIdle, StRead} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
   logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
   logic             wr_bank_q, wr_bank_d;
   logic             rd_bank_q, rd_bank_d;
   logic [1:0]       rd_mode_q, rd_mode_d;
   logic [1:0]       bank_mode_q [2];

   logic [DATA_WIDTH-1:0] mem       [2][BLOCK];
   logic [DATA_WIDTH-1:0] perm_data [LANES];

   logic       accept;
   logic       wr_first;
   logic       wr_last;
   logic       rd_last;
   logic [1:0] blk_mode;

   // Source element for output position m under the selected permutation.
   function automatic logic [IDX_W-1:0] perm_index(input logic [IDX_W-1:0] m,
                                                    input logic [1:0]       sel);
      int unsigned      mi;
      logic [IDX_W-1:0] p;
      mi = 32'(m);
      p  = m;
      case (sel)
         2'd1: p = IDX_W'((mi % R) * LANES + mi / R);
`ifdef SPN_BITREV_EN
         2'd2: begin
            for (int b = 0; b < int'(IDX_W); b++) begin
               p[b] = m[int'(IDX_W) - 1 - b];
            end
         end
`endif
         default: p = m;
      endcase
      return p;
   endfunction

   assign accept   = valid_in & ~rst;
   assign wr_first = accept && (wr_cnt_q == '0);
   assign wr_last  = accept && (wr_cnt_q == CNT_W'(R - 1));
   assign rd_last  = (state_q == StRead) && (rd_cnt_q == CNT_W'(R - 1));

   // A one-beat block (R == 1) has its mode on the same beat that completes it.
   assign blk_mode = wr_first ? mode : bank_mode_q[wr_bank_q];

   always_comb begin
      wr_cnt_d  = wr_cnt_q;
      wr_bank_d = wr_bank_q;
      if (accept) begin
         wr_cnt_d = wr_last ? '0 : wr_cnt_q + CNT_W'(1);
         if (wr_last) begin
            wr_bank_d = ~wr_bank_q;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      rd_cnt_d  = rd_cnt_q;
      rd_bank_d = rd_bank_q;
      rd_mode_d = rd_mode_q;
      case (state_q)
         StIdle: begin
            if (wr_last) begin
               state_d   = StRead;
               rd_cnt_d  = '0;
               rd_bank_d = wr_bank_q;
               rd_mode_d = blk_mode;
            end
         end
         StRead: begin
            // A block completing on the final readout cycle chains straight into the next readout.
            if (wr_last) begin
               state_d   = StRead;
               rd_cnt_d  = '0;
               rd_bank_d = wr_bank_q;
               rd_mode_d = blk_mode;
            end else if (rd_last) begin
               state_d  = StIdle;
               rd_cnt_d = '0;
            end else begin
               rd_cnt_d = rd_cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d  = StIdle;
            rd_cnt_d = '0;
         end
      endcase
   end

   always_comb begin
      for (int l = 0; l < int'(LANES); l++) begin
         perm_data[l] = mem[rd_bank_q][perm_index(IDX_W'(32'(rd_cnt_q) * LANES + 32'(l)),
                                                  rd_mode_q)];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         wr_cnt_q  <= '0;
         rd_cnt_q  <= '0;
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
         rd_mode_q <= 2'd0;
         valid_out <= 1'b0;
         sob_out   <= 1'b0;
         for (int l = 0; l < int'(LANES); l++) begin
            output_stream[l] <= '0;
         end
      end else begin
         state_q   <= state_d;
         wr_cnt_q  <= wr_cnt_d;
         rd_cnt_q  <= rd_cnt_d;
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         rd_mode_q <= rd_mode_d;
         valid_out <= (state_q == StRead);
         sob_out   <= (state_q == StRead) && (rd_cnt_q == '0);
         if (state_q == StRead) begin
            for (int l = 0; l < int'(LANES); l++) begin
               output_stream[l] <= perm_data[l];
            end
         end
      end
   end

   // Bank storage carries no reset; stale contents are never read before being rewritten.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int l = 0; l < int'(LANES); l++) begin
            mem[wr_bank_q][IDX_W'(32'(wr_cnt_q) * LANES + 32'(l))] <= input_stream[l];
         end
         if (wr_first) begin
            bank_mode_q[wr_bank_q] <= mode;
         end
      end
   end

endmodule
